// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side responder for the core's load/store port: a word-organised RAM
//   with byte lanes, a programmable wait-state counter and a registered
//   ready/error handshake.
// Ports:
//   clk         in   1   clock, rising edge
//   reset       in   1   synchronous, active-low reset
//   Mem_Req     in   1   request valid, held with stable inputs until Mem_Ready
//   Mem_WE      in   1   1 = store, 0 = load
//   Mem_WrAddr  in   32  byte address
//   Mem_WrData  in   32  right-aligned store data
//   Funct3      in   3   access size/sign (Instr[14:12])
//   ReadData    out  32  extended load result, 0 unless Mem_Ready
//   Mem_Ready   out  1   single-cycle response strobe
//   Mem_Err     out  1   access rejected, qualified by Mem_Ready
module data_mem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Mem_Req,
  input  logic        Mem_WE,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  input  logic [2:0]  Funct3,
  output logic [31:0] ReadData,
  output logic        Mem_Ready,
  output logic        Mem_Err
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [32:0] SPAN      = 33'(DEPTH) << 2;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [1:0]      lane_q, lane_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [2:0]      f3_q, f3_d;
  logic            err_q, err_d;
  logic [31:0]     res_q, res_d;
  logic            ready_q, ready_d;
  logic            merr_q, merr_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [31:0]     mem [DEPTH];

  logic [32:0]     req_off_s;
  logic            req_ok_s;
  logic            f3_ok_s;
  logic            align_ok_s;
  logic [31:0]     rd_word_s;
  logic [31:0]     wr_word_s;
  logic [31:0]     load_s;
  logic [7:0]      byte_s;
  logic [15:0]     half_s;
  logic            mem_we_s;

  // Request check on the live inputs; a 33-bit offset makes addresses below
  // BASE_ADDR wrap to a huge value so one compare covers both range ends.
  always_comb begin
    req_off_s = {1'b0, Mem_WrAddr} - {1'b0, BASE_ADDR};
    case (Funct3)
      3'b000, 3'b001, 3'b010: f3_ok_s = 1'b1;
      3'b100, 3'b101:         f3_ok_s = ~Mem_WE;
      default:                f3_ok_s = 1'b0;
    endcase
    case (Funct3[1:0])
      2'b01:   align_ok_s = ~Mem_WrAddr[0];
      2'b10:   align_ok_s = (Mem_WrAddr[1:0] == 2'b00);
      default: align_ok_s = 1'b1;
    endcase
    req_ok_s = (req_off_s < SPAN) && f3_ok_s && align_ok_s;
  end

  // Lane extraction for loads and lane merge for stores on the addressed word.
  always_comb begin
    rd_word_s = mem[idx_q];
    case (lane_q)
      2'd0:    byte_s = rd_word_s[7:0];
      2'd1:    byte_s = rd_word_s[15:8];
      2'd2:    byte_s = rd_word_s[23:16];
      2'd3:    byte_s = rd_word_s[31:24];
      default: byte_s = 8'd0;
    endcase
    if (lane_q[1]) begin
      half_s = rd_word_s[31:16];
    end else begin
      half_s = rd_word_s[15:0];
    end
    case (f3_q[1:0])
      2'b00:   load_s = f3_q[2] ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
      2'b01:   load_s = f3_q[2] ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
      2'b10:   load_s = rd_word_s;
      default: load_s = 32'd0;
    endcase
    wr_word_s = rd_word_s;
    case (f3_q[1:0])
      2'b00: begin
        case (lane_q)
          2'd0:    wr_word_s[7:0]   = wdata_q[7:0];
          2'd1:    wr_word_s[15:8]  = wdata_q[7:0];
          2'd2:    wr_word_s[23:16] = wdata_q[7:0];
          2'd3:    wr_word_s[31:24] = wdata_q[7:0];
          default: wr_word_s        = rd_word_s;
        endcase
      end
      2'b01: begin
        if (lane_q[1]) begin
          wr_word_s[31:16] = wdata_q[15:0];
        end else begin
          wr_word_s[15:0]  = wdata_q[15:0];
        end
      end
      2'b10:   wr_word_s = wdata_q;
      default: wr_word_s = rd_word_s;
    endcase
  end

  // Next-state logic: capture, wait countdown, access on the edge leaving WAIT.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    idx_d    = idx_q;
    lane_d   = lane_q;
    wdata_d  = wdata_q;
    f3_d     = f3_q;
    err_d    = err_q;
    res_d    = res_q;
    mem_we_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Mem_Req) begin
          we_d    = Mem_WE;
          idx_d   = req_off_s[AW+1:2];
          lane_d  = Mem_WrAddr[1:0];
          wdata_d = Mem_WrData;
          f3_d    = Funct3;
          res_d   = 32'd0;
          if (req_ok_s) begin
            err_d   = 1'b0;
            cnt_d   = WAIT_INIT;
            state_d = S_WAIT;
          end else begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          mem_we_s = we_q;
          res_d    = we_q ? 32'd0 : load_s;
          state_d  = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: the response is presented for the single cycle after RESP.
  always_comb begin
    if (state_q == S_RESP) begin
      ready_d = 1'b1;
      merr_d  = err_q;
      rdata_d = res_q;
    end else begin
      ready_d = 1'b0;
      merr_d  = 1'b0;
      rdata_d = 32'd0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      lane_q  <= 2'd0;
      wdata_q <= 32'd0;
      f3_q    <= 3'd0;
      err_q   <= 1'b0;
      res_q   <= 32'd0;
      ready_q <= 1'b0;
      merr_q  <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      err_q   <= err_d;
      res_q   <= res_d;
      ready_q <= ready_d;
      merr_q  <= merr_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM write port; contents survive reset, but a reset edge blocks the write.
  always_ff @(posedge clk) begin
    if (reset && mem_we_s) begin
      mem[idx_q] <= wr_word_s;
    end
  end

  assign ReadData  = rdata_q;
  assign Mem_Ready = ready_q;
  assign Mem_Err   = merr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        Mem_Req;
  logic        Mem_WE;
  logic [31:0] Mem_WrAddr;
  logic [31:0] Mem_WrData;
  logic [2:0]  Funct3;
  logic [31:0] ReadData;
  logic        Mem_Ready;
  logic        Mem_Err;

  int total = 0;
  int bad   = 0;

  data_mem_responder dut (
    .clk        (clk),
    .reset      (reset),
    .Mem_Req    (Mem_Req),
    .Mem_WE     (Mem_WE),
    .Mem_WrAddr (Mem_WrAddr),
    .Mem_WrData (Mem_WrData),
    .Funct3     (Funct3),
    .ReadData   (ReadData),
    .Mem_Ready  (Mem_Ready),
    .Mem_Err    (Mem_Err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete request; lat counts edges after the accepting edge (edge 0).
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [2:0] f3, output logic [31:0] rd, output logic err,
                        output int lat);
    Mem_WE     = we;
    Mem_WrAddr = addr;
    Mem_WrData = data;
    Funct3     = f3;
    Mem_Req    = 1'b1;
    lat = -1;
    rd  = 32'd0;
    err = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (Mem_Ready) begin
        lat = k;
        rd  = ReadData;
        err = Mem_Err;
        break;
      end
    end
    Mem_Req = 1'b0;
  endtask

  logic [31:0] rd;
  logic        err;
  int          lat;

  initial begin
    vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 3'b010, 32'h0,        1'b0, 4};
    vecs[1]  = '{1'b0, 32'h10,   32'h0,        3'b010, 32'hDEADBEEF, 1'b0, 4};
    vecs[2]  = '{1'b1, 32'h20,   32'h11223344, 3'b010, 32'h0,        1'b0, 4};
    vecs[3]  = '{1'b1, 32'h23,   32'h00000080, 3'b000, 32'h0,        1'b0, 4};
    vecs[4]  = '{1'b0, 32'h20,   32'h0,        3'b010, 32'h80223344, 1'b0, 4};
    vecs[5]  = '{1'b0, 32'h23,   32'h0,        3'b000, 32'hFFFFFF80, 1'b0, 4};
    vecs[6]  = '{1'b0, 32'h23,   32'h0,        3'b100, 32'h00000080, 1'b0, 4};
    vecs[7]  = '{1'b1, 32'h22,   32'h00008001, 3'b001, 32'h0,        1'b0, 4};
    vecs[8]  = '{1'b0, 32'h22,   32'h0,        3'b001, 32'hFFFF8001, 1'b0, 4};
    vecs[9]  = '{1'b0, 32'h22,   32'h0,        3'b101, 32'h00008001, 1'b0, 4};
    vecs[10] = '{1'b0, 32'h20,   32'h0,        3'b101, 32'h00003344, 1'b0, 4};
    vecs[11] = '{1'b0, 32'h21,   32'h0,        3'b000, 32'h00000033, 1'b0, 4};
    vecs[12] = '{1'b0, 32'h12,   32'h0,        3'b010, 32'h0,        1'b1, 1};
    vecs[13] = '{1'b1, 32'h21,   32'h0000FFFF, 3'b001, 32'h0,        1'b1, 1};
    vecs[14] = '{1'b0, 32'h20,   32'h0,        3'b011, 32'h0,        1'b1, 1};
    vecs[15] = '{1'b0, 32'h1000, 32'h0,        3'b010, 32'h0,        1'b1, 1};
    vecs[16] = '{1'b1, 32'h20,   32'hFFFFFFFF, 3'b100, 32'h0,        1'b1, 1};
    vecs[17] = '{1'b0, 32'h20,   32'h0,        3'b010, 32'h80013344, 1'b0, 4};
    vecs[18] = '{1'b1, 32'hFFC,  32'hCAFEF00D, 3'b010, 32'h0,        1'b0, 4};
    vecs[19] = '{1'b0, 32'hFFC,  32'h0,        3'b010, 32'hCAFEF00D, 1'b0, 4};

    reset = 1'b0; Mem_Req = 1'b0; Mem_WE = 1'b0;
    Mem_WrAddr = 32'h0; Mem_WrData = 32'h0; Funct3 = 3'b000;
    tick();
    tick();
    chk("rst_ready", {31'd0, Mem_Ready}, 32'd0);
    chk("rst_err",   {31'd0, Mem_Err},   32'd0);
    chk("rst_rdata", ReadData,           32'd0);
    reset = 1'b1;

    // Reset held with a live store request: nothing may be written.
    access(1'b1, 32'h30, 32'h12345678, 3'b010, rd, err, lat);
    chk("pre_sw_lat", lat, 32'd4);
    Mem_WE = 1'b1; Mem_WrAddr = 32'h30; Mem_WrData = 32'h55555555; Funct3 = 3'b010;
    Mem_Req = 1'b1; reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("rstreq%0d_ready", c), {31'd0, Mem_Ready}, 32'd0);
      chk($sformatf("rstreq%0d_err", c),   {31'd0, Mem_Err},   32'd0);
      chk($sformatf("rstreq%0d_rdata", c), ReadData,           32'd0);
    end
    reset = 1'b1; Mem_Req = 1'b0;
    tick();
    access(1'b0, 32'h30, 32'h0, 3'b010, rd, err, lat);
    chk("rstreq_nowrite", rd, 32'h12345678);

    for (int i = 0; i < 20; i++) begin
      access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, rd, err, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
    end

    // Back-to-back: Req stays high across the response.
    Mem_WE = 1'b0; Mem_WrAddr = 32'h10; Mem_WrData = 32'h0; Funct3 = 3'b010;
    Mem_Req = 1'b1;
    for (int e = 0; e < 4; e++) tick();
    chk("b2b_early", {31'd0, Mem_Ready}, 32'd0);
    tick();
    chk("b2b_first_ready", {31'd0, Mem_Ready}, 32'd1);
    chk("b2b_first_rdata", ReadData, 32'hDEADBEEF);
    Mem_WrAddr = 32'h20;
    tick();
    chk("b2b_one_cycle", {31'd0, Mem_Ready}, 32'd0);
    for (int e = 0; e < 3; e++) tick();
    chk("b2b_second_early", {31'd0, Mem_Ready}, 32'd0);
    tick();
    chk("b2b_second_ready", {31'd0, Mem_Ready}, 32'd1);
    chk("b2b_second_rdata", ReadData, 32'h80013344);
    Mem_Req = 1'b0;
    tick();
    chk("b2b_after", {31'd0, Mem_Ready}, 32'd0);

    // Reset while a store is still waiting: discarded.
    Mem_WE = 1'b1; Mem_WrAddr = 32'h10; Mem_WrData = 32'h77777777; Funct3 = 3'b010;
    Mem_Req = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("abort_ready", {31'd0, Mem_Ready}, 32'd0);
    reset = 1'b1; Mem_Req = 1'b0;
    tick();
    access(1'b0, 32'h10, 32'h0, 3'b010, rd, err, lat);
    chk("abort_word_kept", rd, 32'hDEADBEEF);

    // Reset after the store was performed: write persists, Ready suppressed.
    Mem_WE = 1'b1; Mem_WrAddr = 32'h10; Mem_WrData = 32'h99999999; Funct3 = 3'b010;
    Mem_Req = 1'b1;
    for (int e = 0; e < 4; e++) tick();
    reset = 1'b0;
    tick();
    chk("late_rst_ready", {31'd0, Mem_Ready}, 32'd0);
    reset = 1'b1; Mem_Req = 1'b0;
    tick();
    access(1'b0, 32'h10, 32'h0, 3'b010, rd, err, lat);
    chk("late_rst_persist", rd, 32'h99999999);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
